nlynx_snapshot_sequencer: RTL and testbench

//  Sequences the NLYNX performance-counter datapath toward the datalynx PS capture logic.
//  On each end-of-period (EOP) rising edge it snapshots all metric counters and overflow flags

---
 rtl/nlynx_snapshot_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_nlynx_snapshot_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nlynx_snapshot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : nlynx_snapshot_sequencer
// Description : Snapshots NLYNX performance counters and overflow flags on each
//               end-of-period rising edge. Streams them out as one AXI4-Stream
//               frame: a header beat, N counter beats and an optional checksum
//               beat.
//               Optional feature macro: NLYNX_CHECKSUM_EN appends an XOR
//               checksum beat to the frame.
// Revision    : 1.0 - initial release
// ============================================================================
module nlynx_snapshot_sequencer #(
    parameter int NLYNX_METRICS       = 13,
    parameter int NLYNX_COUNTER_WIDTH = 32,
    parameter int SEQ_WIDTH           = 16
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    input  logic                                         en_i,
    input  logic                                         eop_i,
    input  logic [NLYNX_METRICS-1:0]                     overflow_i,
    input  logic [NLYNX_METRICS*NLYNX_COUNTER_WIDTH-1:0] cnt_i,
    output logic [NLYNX_COUNTER_WIDTH-1:0]               m_tdata_o,
    output logic                                         m_tvalid_o,
    input  logic                                         m_tready_i,
    output logic                                         m_tlast_o,
    output logic                                         busy_o,
    output logic [SEQ_WIDTH-1:0]                         seq_o,
    output logic [15:0]                                  drop_cnt_o
);

    localparam int                W        = NLYNX_COUNTER_WIDTH;
    localparam int                IDX_W    = (NLYNX_METRICS > 1) ? $clog2(NLYNX_METRICS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NLYNX_METRICS - 1);
`ifdef NLYNX_CHECKSUM_EN
    localparam logic              HAS_CSUM = 1'b1;
`else
    localparam logic              HAS_CSUM = 1'b0;
`endif

`ifdef NLYNX_CHECKSUM_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2,
        S_CSUM = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2
    } state_t;
`endif

    // Header layout: sequence number in [31:16], overflow flags in [15:0].
    function automatic logic [W-1:0] f_header(input logic [SEQ_WIDTH-1:0]     seq,
                                              input logic [NLYNX_METRICS-1:0] ovf);
        logic [W-1:0] hdr;
        hdr        = '0;
        hdr[31:16] = 16'(seq);
        hdr[15:0]  = 16'(ovf);
        return hdr;
    endfunction

    state_t                  r_state;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_tvalid;
    logic                    r_tlast;
    logic [W-1:0]            r_tdata;
    logic [SEQ_WIDTH-1:0]    r_seq;
    logic [15:0]             r_drop;
    logic                    r_eop_q;
    logic [W-1:0]            r_cnt [NLYNX_METRICS];
    logic [NLYNX_METRICS-1:0] r_ovf;

    logic                    w_rise;
    logic                    w_accept;
    logic                    w_drop;
    logic                    w_hs;
    logic [SEQ_WIDTH-1:0]    w_seq_nxt;
    logic [IDX_W-1:0]        w_idx_nxt;

    assign w_rise    = eop_i & ~r_eop_q;
    assign w_accept  = w_rise & en_i & (r_state == S_IDLE);
    assign w_drop    = w_rise & en_i & (r_state != S_IDLE);
    assign w_hs      = r_tvalid & m_tready_i;
    assign w_seq_nxt = r_seq + 1'b1;
    assign w_idx_nxt = r_idx + 1'b1;

`ifdef NLYNX_CHECKSUM_EN
    // Checksum is built only from shadow state, so it cannot move mid-frame.
    logic [W-1:0] w_csum;
    always_comb begin
        w_csum = f_header(r_seq, r_ovf);
        for (int k = 0; k < NLYNX_METRICS; k++) begin
            w_csum = w_csum ^ r_cnt[k];
        end
    end
`endif

    // Delay EOP by one cycle for rising-edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_eop_q <= 1'b0;
        end else begin
            r_eop_q <= eop_i;
        end
    end

    // Shadow copy of counters and overflow flags taken on an accepted edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ovf <= '0;
            for (int k = 0; k < NLYNX_METRICS; k++) begin
                r_cnt[k] <= '0;
            end
        end else if (w_accept) begin
            r_ovf <= overflow_i;
            for (int k = 0; k < NLYNX_METRICS; k++) begin
                r_cnt[k] <= cnt_i[k*W +: W];
            end
        end
    end

    // Count EOP edges that arrive while a frame is still in flight (saturating).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_drop <= 16'd0;
        end else if (w_drop && (r_drop != 16'hFFFF)) begin
            r_drop <= r_drop + 16'd1;
        end
    end

    // Frame sequencer; every stream output is registered and only advances on a handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tdata  <= '0;
            r_seq    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state  <= S_HDR;
                        r_seq    <= w_seq_nxt;
                        r_tvalid <= 1'b1;
                        r_tlast  <= 1'b0;
                        r_tdata  <= f_header(w_seq_nxt, overflow_i);
                    end
                end
                S_HDR: begin
                    if (w_hs) begin
                        r_state <= S_DATA;
                        r_idx   <= '0;
                        r_tdata <= r_cnt[0];
                        r_tlast <= ~HAS_CSUM & (LAST_IDX == '0);
                    end
                end
                S_DATA: begin
                    if (w_hs) begin
                        if (r_idx != LAST_IDX) begin
                            r_idx   <= w_idx_nxt;
                            r_tdata <= r_cnt[w_idx_nxt];
                            r_tlast <= ~HAS_CSUM & (w_idx_nxt == LAST_IDX);
                        end else begin
`ifdef NLYNX_CHECKSUM_EN
                            r_state <= S_CSUM;
                            r_tdata <= w_csum;
                            r_tlast <= 1'b1;
`else
                            r_state  <= S_IDLE;
                            r_tvalid <= 1'b0;
                            r_tlast  <= 1'b0;
                            r_tdata  <= '0;
`endif
                        end
                    end
                end
`ifdef NLYNX_CHECKSUM_EN
                S_CSUM: begin
                    if (w_hs) begin
                        r_state  <= S_IDLE;
                        r_tvalid <= 1'b0;
                        r_tlast  <= 1'b0;
                        r_tdata  <= '0;
                    end
                end
`endif
                default: begin
                    r_state  <= S_IDLE;
                    r_tvalid <= 1'b0;
                    r_tlast  <= 1'b0;
                    r_tdata  <= '0;
                end
            endcase
        end
    end

    assign m_tdata_o  = r_tdata;
    assign m_tvalid_o = r_tvalid;
    assign m_tlast_o  = r_tlast;
    assign busy_o     = (r_state != S_IDLE);
    assign seq_o      = r_seq;
    assign drop_cnt_o = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_nlynx_snapshot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_nlynx_snapshot_sequencer
// Description : Self-checking bench for nlynx_snapshot_sequencer. A queue of
//               expected beats is built from the frame format whenever an EOP
//               edge is accepted, and drained on each modelled handshake.
//               Honours NLYNX_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nlynx_snapshot_sequencer;

    localparam int M = 13;
    localparam int W = 32;
    localparam int S = 16;
`ifdef NLYNX_CHECKSUM_EN
    localparam int FLEN = M + 2;
`else
    localparam int FLEN = M + 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             eop;
    logic [M-1:0]     ovf;
    logic [M*W-1:0]   cnt;
    logic [W-1:0]     tdata;
    logic             tvalid;
    logic             tready;
    logic             tlast;
    logic             busy;
    logic [S-1:0]     seq;
    logic [15:0]      drop;

    always #5 clk = ~clk;

    nlynx_snapshot_sequencer #(
        .NLYNX_METRICS       (M),
        .NLYNX_COUNTER_WIDTH (W),
        .SEQ_WIDTH           (S)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (en),
        .eop_i      (eop),
        .overflow_i (ovf),
        .cnt_i      (cnt),
        .m_tdata_o  (tdata),
        .m_tvalid_o (tvalid),
        .m_tready_i (tready),
        .m_tlast_o  (tlast),
        .busy_o     (busy),
        .seq_o      (seq),
        .drop_cnt_o (drop)
    );

    int n_err = 0;
    int n_chk = 0;

    // Reference model state
    logic [W-1:0] mq[$];     // beats still owed; front is the beat on the bus
    logic [W-1:0] obs[$];    // beats handed over, in order
    logic [S-1:0] m_seq;
    logic [15:0]  m_drop;
    logic         m_eop_prev;
    int           dut_frames = 0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_chk++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Build the whole expected frame from the current inputs and model sequence number.
    task automatic push_frame();
        logic [W-1:0] hdr;
        logic [W-1:0] x;
        hdr        = '0;
        hdr[31:16] = m_seq;
        hdr[15:0]  = 16'(ovf);
        mq.push_back(hdr);
        x = hdr;
        for (int k = 0; k < M; k++) begin
            mq.push_back(cnt[k*W +: W]);
            x = x ^ cnt[k*W +: W];
        end
`ifdef NLYNX_CHECKSUM_EN
        mq.push_back(x);
`endif
    endtask

    // Compare outputs, advance the model across the coming edge, then step one clock.
    task automatic cycle();
        bit owed;
        bit hs;
        bit rise;
        owed = (mq.size() != 0);
        check("tvalid", tvalid, owed);
        check("busy", busy, owed);
        check("seq", seq, m_seq);
        check("drop", drop, m_drop);
        if (owed) begin
            check("tdata", tdata, mq[0]);
            check("tlast", tlast, mq.size() == 1);
        end
        if (tvalid === 1'b1 && tready && tlast === 1'b1) dut_frames++;
        hs   = owed && tready;
        rise = eop && !m_eop_prev;
        if (hs) begin
            obs.push_back(mq[0]);
            void'(mq.pop_front());
        end
        if (rise && en) begin
            if (owed) begin
                if (m_drop != 16'hFFFF) m_drop++;
            end else begin
                m_seq++;
                push_frame();
            end
        end
        m_eop_prev = eop;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        eop   = 1'b0;
        #1;
        check("rst_tvalid", tvalid, 0);
        check("rst_tlast", tlast, 0);
        check("rst_tdata", tdata, 0);
        check("rst_busy", busy, 0);
        check("rst_seq", seq, 0);
        check("rst_drop", drop, 0);
        mq.delete();
        m_seq      = '0;
        m_drop     = '0;
        m_eop_prev = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input bit rnd_ready, input int budget);
        while (mq.size() != 0 && budget > 0) begin
            tready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            cycle();
            budget--;
        end
        check("drain_bound", mq.size(), 0);
        tready = 1'b1;
    endtask

    task automatic pulse_eop();
        eop = 1'b1;
        cycle();
        eop = 1'b0;
    endtask

    int frames0;

    initial begin
        rst_n = 1'b0; en = 1'b0; eop = 1'b0; tready = 1'b0;
        ovf = '0; cnt = '0;
        m_seq = '0; m_drop = '0; m_eop_prev = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Step 1: single frame, counters k+1, overflow 5, always ready
        en = 1'b1; tready = 1'b1; ovf = 13'h0005;
        for (int k = 0; k < M; k++) cnt[k*W +: W] = 32'(k + 1);
        cycle();
        obs.delete();
        pulse_eop();
        drain(1'b0, 100);
        cycle();
        check("t1_len", obs.size(), FLEN);
        check("t1_hdr", obs[0], 32'h0001_0005);
        check("t1_d1", obs[1], 32'd1);
        check("t1_d13", obs[M], 32'd13);
`ifdef NLYNX_CHECKSUM_EN
        check("t1_csum", obs[FLEN-1], 32'h0001_0004);
`endif
        check("t1_seq", seq, 1);

        // Step 2: same frame under random backpressure
        obs.delete();
        pulse_eop();
        drain(1'b1, 400);
        cycle();
        check("t2_len", obs.size(), FLEN);
        check("t2_hdr", obs[0], 32'h0002_0005);
        check("t2_d7", obs[7], 32'd7);

        // Step 3: edges during the frame and on the last-beat handshake are dropped
        do_reset();
        frames0 = dut_frames;
        pulse_eop();
        for (int i = 0; i < 3; i++) cycle();
        pulse_eop();
        for (int i = 0; i < 100 && mq.size() > 1; i++) cycle();
        eop = 1'b1;
        cycle();
        eop = 1'b0;
        cycle();
        cycle();
        check("t3_drop", drop, 2);
        check("t3_seq", seq, 1);
        check("t3_frames", dut_frames - frames0, 1);

        // Step 4: disabled edges are ignored; disabling mid-frame still completes it
        en = 1'b0;
        frames0 = dut_frames;
        for (int i = 0; i < 3; i++) begin
            pulse_eop();
            cycle();
        end
        check("t4_drop", drop, 2);
        check("t4_noframe", dut_frames - frames0, 0);
        en = 1'b1;
        pulse_eop();
        cycle();
        en = 1'b0;
        drain(1'b1, 400);
        cycle();
        check("t4_frames", dut_frames - frames0, 1);
        check("t4_seq", seq, 2);
        en = 1'b1;

        // Step 5: reset on beat 5 abandons the frame; sequence restarts
        pulse_eop();
        for (int i = 0; i < 5; i++) cycle();
        do_reset();
        pulse_eop();
        check("t5_hdr_seq", tdata[31:16], 1);
        drain(1'b0, 100);
        cycle();

`ifdef NLYNX_CHECKSUM_EN
        // Step 6: checksum beat over uniform counters
        do_reset();
        ovf = '0;
        for (int k = 0; k < M; k++) cnt[k*W +: W] = 32'hA5A5_A5A5;
        obs.delete();
        pulse_eop();
        drain(1'b0, 100);
        cycle();
        check("t6_len", obs.size(), 15);
        check("t6_csum", obs[14], 32'h0001_0000 ^ 32'hA5A5_A5A5);
`endif

        // Random traffic: counters, flags, enable, EOP and backpressure all vary
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < M; k++) cnt[k*W +: W] = $urandom();
            ovf    = M'($urandom());
            en     = ($urandom_range(0, 7) != 0);
            eop    = ($urandom_range(0, 3) == 0);
            tready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        eop = 1'b0;
        drain(1'b1, 400);
        cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
